// File: rtl/alu_exec_pkg.sv
// Shared bus widths, op encodings and write-back entry layout for the ALU
// execution / write-back slice.
package alu_exec_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned TAG_W       = 5;
  localparam int unsigned OP_W        = 5;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned BTAG_W      = 4;
  localparam int unsigned BNUM_W      = 2;
  localparam int unsigned ALUbufDepth = 2;

  typedef logic [DATA_W-1:0] data_bus_t;
  typedef logic [TAG_W-1:0]  tag_bus_t;
  typedef logic [OP_W-1:0]   op_bus_t;
  typedef logic [ADDR_W-1:0] inst_addr_bus_t;
  typedef logic [BTAG_W-1:0] branch_tag_bus_t;
  typedef logic [BNUM_W-1:0] branch_num_t;

  localparam tag_bus_t  tagFree  = '0;
  localparam data_bus_t dataFree = '0;
  localparam logic      Enable   = 1'b1;
  localparam logic      Disable  = 1'b0;

  typedef enum logic [OP_W-1:0] {
    OP_NOP   = 5'd0,
    OP_ADD   = 5'd1,
    OP_SUB   = 5'd2,
    OP_SLL   = 5'd3,
    OP_SLT   = 5'd4,
    OP_SLTU  = 5'd5,
    OP_XOR   = 5'd6,
    OP_SRL   = 5'd7,
    OP_SRA   = 5'd8,
    OP_OR    = 5'd9,
    OP_AND   = 5'd10,
    OP_LUI   = 5'd11,
    OP_AUIPC = 5'd12,
    OP_JAL   = 5'd13,
    OP_JALR  = 5'd14
  } op_e;

  typedef struct packed {
    tag_bus_t        tag;
    data_bus_t       data;
    branch_tag_bus_t mask;
  } wb_entry_t;

  // A speculative result dies when its branch slot resolves as mispredicted.
  function automatic logic is_killed(input branch_tag_bus_t mask, input logic mis_taken,
                                     input logic b_free_en, input branch_num_t b_free_num);
    return mis_taken & b_free_en & mask[b_free_num];
  endfunction

  function automatic branch_tag_bus_t untag(input branch_tag_bus_t mask,
                                            input branch_num_t b_free_num);
    return mask & ~(BTAG_W'(1) << b_free_num);
  endfunction

endpackage

// File: rtl/alu_exec_core.sv
// Combinational RV32I integer op evaluation.
module alu_core
  import alu_exec_pkg::*;
(
  input  logic [OP_W-1:0]   opCode,
  input  logic [DATA_W-1:0] operandO,
  input  logic [DATA_W-1:0] operandT,
  input  logic [ADDR_W-1:0] instAddr,
  output logic [DATA_W-1:0] result_c
);

  logic [4:0] shamt;

  assign shamt = operandT[4:0];

  always_comb begin
    result_c = dataFree;
    case (opCode)
      OP_ADD:   result_c = operandO + operandT;
      OP_SUB:   result_c = operandO - operandT;
      OP_SLL:   result_c = operandO << shamt;
      OP_SLT:   result_c = DATA_W'($signed(operandO) < $signed(operandT));
      OP_SLTU:  result_c = DATA_W'(operandO < operandT);
      OP_XOR:   result_c = operandO ^ operandT;
      OP_SRL:   result_c = operandO >> shamt;
      OP_SRA:   result_c = DATA_W'($signed(operandO) >>> shamt);
      OP_OR:    result_c = operandO | operandT;
      OP_AND:   result_c = operandO & operandT;
      OP_LUI:   result_c = operandT;
      OP_AUIPC: result_c = DATA_W'(instAddr + ADDR_W'(operandT));
      OP_JAL,
      OP_JALR:  result_c = DATA_W'(instAddr + ADDR_W'(4));
      default:  result_c = dataFree;
    endcase
  end

endmodule

// File: rtl/alu_exec.sv
// ALU execution and write-back: computes results and holds them in a
// 2-entry buffer until the CDB arbiter grants the result bus.
module alu_exec
  import alu_exec_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                ALUworkEn,
  input  logic [DATA_W-1:0]   operandO,
  input  logic [DATA_W-1:0]   operandT,
  input  logic [OP_W-1:0]     opCode,
  input  logic [TAG_W-1:0]    wrtTag,
  input  logic [ADDR_W-1:0]   instAddr,
  input  logic [BTAG_W-1:0]   instBranchTag,
  input  logic                cdbGrant,
  input  logic                bFreeEn,
  input  logic [BNUM_W-1:0]   bFreeNum,
  input  logic                misTaken,
  output logic                enALUwrt,
  output logic [TAG_W-1:0]    ALUtag,
  output logic [DATA_W-1:0]   ALUdata,
  output logic                aluStall,
  output logic                aluOvf
);

  wb_entry_t   wb_q [ALUbufDepth];
  wb_entry_t   wb_d [ALUbufDepth];
  logic [1:0]  count_q;
  logic [1:0]  count_d;
  logic        ovf_set;
  logic        head_vis;
  logic        pop;
  logic        push_req;
  logic        untag_en;
  logic [DATA_W-1:0] result;
  wb_entry_t   in_entry;

  alu_core u_core (
    .opCode   (opCode),
    .operandO (operandO),
    .operandT (operandT),
    .instAddr (instAddr),
    .result_c (result)
  );

  // Head is hidden the same cycle its branch resolves as mispredicted.
  assign head_vis = rdy & (count_q != 2'd0)
                  & ~is_killed(wb_q[0].mask, misTaken, bFreeEn, bFreeNum);
  assign pop      = head_vis & cdbGrant;
  assign push_req = ALUworkEn & ~is_killed(instBranchTag, misTaken, bFreeEn, bFreeNum);
  assign untag_en = bFreeEn & ~misTaken;
  assign ovf_set  = rdy & push_req & (count_q == 2'd2) & ~pop;

  assign enALUwrt = head_vis;
  assign ALUtag   = head_vis ? wb_q[0].tag  : tagFree;
  assign ALUdata  = head_vis ? wb_q[0].data : dataFree;
  assign aluStall = (count_q == 2'd2);

  always_comb begin
    in_entry.tag  = wrtTag;
    in_entry.data = result;
    in_entry.mask = untag_en ? untag(instBranchTag, bFreeNum) : instBranchTag;
  end

  // Drop popped/killed entries, compact survivors to the head, then append.
  always_comb begin
    wb_entry_t e;
    wb_d[0] = '0;
    wb_d[1] = '0;
    count_d = 2'd0;
    e       = '0;
    for (int i = 0; i < ALUbufDepth; i++) begin
      e = wb_q[i];
      if ((2'(i) < count_q) && !(i == 0 && pop)
          && !is_killed(e.mask, misTaken, bFreeEn, bFreeNum)) begin
        if (untag_en) e.mask = untag(e.mask, bFreeNum);
        wb_d[count_d[0]] = e;
        count_d = count_d + 2'd1;
      end
    end
    if (push_req && !((count_q == 2'd2) && !pop)) begin
      wb_d[count_d[0]] = in_entry;
      count_d = count_d + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= 2'd0;
      wb_q[0] <= '0;
      wb_q[1] <= '0;
      aluOvf  <= 1'b0;
    end else if (rdy) begin
      count_q <= count_d;
      wb_q[0] <= wb_d[0];
      wb_q[1] <= wb_d[1];
      if (ovf_set) aluOvf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Directed self-checking bench for alu_exec.
module tb_alu_exec;
  import alu_exec_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              rdy;
  logic              ALUworkEn;
  logic [DATA_W-1:0] operandO;
  logic [DATA_W-1:0] operandT;
  logic [OP_W-1:0]   opCode;
  logic [TAG_W-1:0]  wrtTag;
  logic [ADDR_W-1:0] instAddr;
  logic [BTAG_W-1:0] instBranchTag;
  logic              cdbGrant;
  logic              bFreeEn;
  logic [BNUM_W-1:0] bFreeNum;
  logic              misTaken;
  logic              enALUwrt;
  logic [TAG_W-1:0]  ALUtag;
  logic [DATA_W-1:0] ALUdata;
  logic              aluStall;
  logic              aluOvf;

  int n_checks = 0;
  int n_pass   = 0;

  alu_exec dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .ALUworkEn     (ALUworkEn),
    .operandO      (operandO),
    .operandT      (operandT),
    .opCode        (opCode),
    .wrtTag        (wrtTag),
    .instAddr      (instAddr),
    .instBranchTag (instBranchTag),
    .cdbGrant      (cdbGrant),
    .bFreeEn       (bFreeEn),
    .bFreeNum      (bFreeNum),
    .misTaken      (misTaken),
    .enALUwrt      (enALUwrt),
    .ALUtag        (ALUtag),
    .ALUdata       (ALUdata),
    .aluStall      (aluStall),
    .aluOvf        (aluOvf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag, input logic [BTAG_W-1:0] mask,
                       input logic [31:0] pc);
    ALUworkEn     = 1'b1;
    opCode        = op;
    operandO      = a;
    operandT      = b;
    wrtTag        = tag;
    instBranchTag = mask;
    instAddr      = pc;
  endtask

  task automatic idle();
    ALUworkEn     = 1'b0;
    opCode        = OP_NOP;
    operandO      = '0;
    operandT      = '0;
    wrtTag        = '0;
    instBranchTag = '0;
    instAddr      = '0;
  endtask

  task automatic branch(input logic en, input logic mis, input logic [1:0] num);
    bFreeEn  = en;
    misTaken = mis;
    bFreeNum = num;
  endtask

  // Streaming op table: op, operandO, operandT, pc, expected result.
  typedef struct {
    op_e         op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [11];

  initial begin
    vecs[0]  = '{OP_SUB,  32'd5,          32'd7,          32'h0,    32'hFFFF_FFFE};
    vecs[1]  = '{OP_SLL,  32'd1,          32'h0000_003F,  32'h0,    32'h8000_0000};
    vecs[2]  = '{OP_SLT,  32'hFFFF_FFFF,  32'd1,          32'h0,    32'd1};
    vecs[3]  = '{OP_SLTU, 32'hFFFF_FFFF,  32'd1,          32'h0,    32'd0};
    vecs[4]  = '{OP_XOR,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0,    32'h0FF0_0FF0};
    vecs[5]  = '{OP_OR,   32'h1200_0034,  32'h0056_7800,  32'h0,    32'h1256_7834};
    vecs[6]  = '{OP_AND,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0,    32'hF000_F000};
    vecs[7]  = '{OP_SRL,  32'h8000_0000,  32'd4,          32'h0,    32'h0800_0000};
    vecs[8]  = '{OP_LUI,  32'h1234_5678,  32'hABCD_E000,  32'h0,    32'hABCD_E000};
    vecs[9]  = '{OP_JALR, 32'h0,          32'h0,          32'hFFFF_FFFC, 32'h0};
    vecs[10] = '{OP_ADD,  32'hFFFF_FFFF,  32'd2,          32'h0,    32'd1};

    rst = 1'b0; rdy = 1'b1; cdbGrant = 1'b1;
    idle();
    branch(1'b0, 1'b0, 2'd0);
    #12;
    check("rst_en",    32'(enALUwrt), 32'd0);
    check("rst_tag",   32'(ALUtag),   32'(tagFree));
    check("rst_data",  ALUdata,       dataFree);
    check("rst_stall", 32'(aluStall), 32'd0);
    check("rst_ovf",   32'(aluOvf),   32'd0);
    step();
    rst = 1'b1;

    // Single ADD, one-cycle latency, granted immediately
    issue(OP_ADD, 32'd5, 32'd7, 5'h13, 4'b0000, 32'h0);
    step(); idle();
    check("add_en",   32'(enALUwrt), 32'd1);
    check("add_tag",  32'(ALUtag),   32'h13);
    check("add_data", ALUdata,       32'd12);
    step();
    check("add_gone", 32'(enALUwrt), 32'd0);

    // Back-to-back streaming with grant held high
    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), 4'b0000, vecs[i].pc);
      step();
      check($sformatf("stream_en_%0d", i),   32'(enALUwrt), 32'd1);
      check($sformatf("stream_data_%0d", i), ALUdata,       vecs[i].exp);
    end
    idle();
    step();
    check("stream_done", 32'(enALUwrt), 32'd0);

    // Grant withheld: accumulate two results
    cdbGrant = 1'b0;
    issue(OP_SRA, 32'h8000_0000, 32'd4, 5'd1, 4'b0000, 32'h0);
    step();
    check("acc1_stall", 32'(aluStall), 32'd0);
    issue(OP_SLTU, 32'd1, 32'hFFFF_FFFF, 5'd2, 4'b0000, 32'h0);
    step(); idle();
    check("acc_stall", 32'(aluStall), 32'd1);
    check("acc_head",  ALUdata,       32'hF800_0000);
    cdbGrant = 1'b1;
    step();
    check("acc_second", ALUdata,       32'd1);
    check("acc_tag2",   32'(ALUtag),   32'd2);
    check("acc_unstall",32'(aluStall), 32'd0);
    step();
    check("acc_empty",  32'(enALUwrt), 32'd0);

    // Full buffer: push with pop is legal, push without pop overflows
    cdbGrant = 1'b0;
    issue(OP_ADD, 32'd1, 32'd1, 5'd3, 4'b0000, 32'h0); step();
    issue(OP_ADD, 32'd2, 32'd2, 5'd4, 4'b0000, 32'h0); step();
    cdbGrant = 1'b1;
    issue(OP_ADD, 32'd3, 32'd3, 5'd5, 4'b0000, 32'h0); step();
    check("full_pp_ovf",   32'(aluOvf),   32'd0);
    check("full_pp_stall", 32'(aluStall), 32'd1);
    check("full_pp_head",  ALUdata,       32'd4);
    cdbGrant = 1'b0;
    issue(OP_ADD, 32'd4, 32'd4, 5'd6, 4'b0000, 32'h0); step(); idle();
    check("ovf_set",  32'(aluOvf), 32'd1);
    check("ovf_head", ALUdata,     32'd4);
    cdbGrant = 1'b1;
    step();
    check("ovf_next", ALUdata, 32'd6);
    step();
    check("ovf_drained", 32'(enALUwrt), 32'd0);
    check("ovf_sticky",  32'(aluOvf),   32'd1);

    // Mispredict kills the head; tail takes over
    cdbGrant = 1'b0;
    issue(OP_ADD, 32'd10, 32'd0, 5'd7, 4'b0010, 32'h0); step();
    issue(OP_ADD, 32'd20, 32'd0, 5'd8, 4'b0000, 32'h0); step(); idle();
    check("kill_pre_head", ALUdata, 32'd10);
    branch(1'b1, 1'b1, 2'd1);
    #1;
    check("kill_hidden", 32'(enALUwrt), 32'd0);
    step();
    branch(1'b0, 1'b0, 2'd0);
    #1;
    check("kill_tail_en",   32'(enALUwrt), 32'd1);
    check("kill_tail_data", ALUdata,       32'd20);
    check("kill_tail_tag",  32'(ALUtag),   32'd8);
    check("kill_stall",     32'(aluStall), 32'd0);
    cdbGrant = 1'b1;
    step();
    check("kill_empty", 32'(enALUwrt), 32'd0);

    // Untag on incoming issue protects it from a later mispredict
    cdbGrant = 1'b0;
    issue(OP_ADD, 32'd30, 32'd0, 5'd9, 4'b0100, 32'h0);
    branch(1'b1, 1'b0, 2'd2);
    step(); idle();
    branch(1'b1, 1'b1, 2'd2);
    #1;
    check("untag_vis",  32'(enALUwrt), 32'd1);
    check("untag_data", ALUdata,       32'd30);
    step();
    branch(1'b0, 1'b0, 2'd0);
    #1;
    check("untag_survive", 32'(enALUwrt), 32'd1);
    cdbGrant = 1'b1;
    step();
    check("untag_empty", 32'(enALUwrt), 32'd0);

    // JAL/AUIPC with rdy freeze mid-stream
    cdbGrant = 1'b0;
    issue(OP_JAL,   32'd0, 32'd0,         5'd10, 4'b0000, 32'h1000); step();
    issue(OP_AUIPC, 32'd0, 32'hFFFF_F000, 5'd11, 4'b0000, 32'h2000); step(); idle();
    check("jal_data", ALUdata, 32'h1004);
    rdy = 1'b0; cdbGrant = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("frz_en_%0d", i),   32'(enALUwrt), 32'd0);
      check($sformatf("frz_data_%0d", i), ALUdata,       dataFree);
      step();
    end
    check("frz_stall", 32'(aluStall), 32'd1);
    rdy = 1'b1;
    #1;
    check("thaw_jal",   ALUdata, 32'h1004);
    step();
    check("thaw_auipc", ALUdata, 32'h1000);
    check("thaw_tag",   32'(ALUtag), 32'd11);
    step();
    check("thaw_empty", 32'(enALUwrt), 32'd0);

    // Asynchronous reset discards a buffered result
    cdbGrant = 1'b0;
    issue(OP_ADD, 32'd9, 32'd9, 5'd12, 4'b0000, 32'h0); step(); idle();
    check("pre_arst", 32'(enALUwrt), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_en",  32'(enALUwrt), 32'd0);
    check("arst_ovf", 32'(aluOvf),   32'd0);
    step();
    rst = 1'b1;
    step();
    check("arst_hold", 32'(enALUwrt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
